regfile_rd: RTL and testbench
=============================

Name: regfile_rd

Overview:
- General-purpose register file at the end of the write-back path. Accepts the single write port driven by the MEM/WB pipeline register and serves two registered read ports to the ID stage.
- Holds 2**RADDR_WIDTH registers; x0 is hardwired to zero.
- Read data is registered, with one-cycle latency. A write and a read of the same register in the same cycle return the new value (write-through bypass).
- ID-stage stalls hold the read outputs. A debug port gives combinational access to the array.

Parameters:
- RADDR_WIDTH, 5, register address width (32 entries); matches the shared `RADDR_WIDTH define.
- RDATA_WIDTH, 32, register data width; matches the shared `RDATA_WIDTH define.
- STALL_BIT, 1, index into stall_i that freezes the read outputs (ID stage).

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  6  pipeline stall vector; bit STALL_BIT holds the read outputs.
- we_i  in  1  write enable, from MEM/WB reg_we_o.
- waddr_i  in  RADDR_WIDTH  write address, from MEM/WB reg_waddr_o.
- wdata_i  in  RDATA_WIDTH  write data, from MEM/WB reg_wdata_o.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  RADDR_WIDTH  read port 1 address.
- rdata1_o  out  RDATA_WIDTH  read port 1 data, registered.
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  RADDR_WIDTH  read port 2 address.
- rdata2_o  out  RDATA_WIDTH  read port 2 data, registered.
- dbg_addr_i  in  RADDR_WIDTH  debug read address.
- dbg_data_o  out  RDATA_WIDTH  debug read data, combinational from the array; no bypass.

Behaviour:
- Reset:
  - rst_ni low asynchronously clears all array entries, rdata1_o and rdata2_o to `ZERO.
  - Writes are ignored while reset is low.
  - Reset deasserting mid-cycle takes effect at the next posedge.
- Write:
  - At posedge, if we_i=1 and waddr_i != `ZERO_REG, array[waddr_i] <= wdata_i.
  - Writes to x0 are dropped.
  - Writes are never stalled: stall_i does not gate them.
- Read (per port n = 1, 2), evaluated at posedge:
  - If stall_i[STALL_BIT]=1: rdata_n_o holds its value, even if a write to the held register occurs. The stalled consumer re-reads after the stall.
  - Else if re_n_i=0: rdata_n_o <= `ZERO.
  - Else if raddr_n_i = `ZERO_REG: rdata_n_o <= `ZERO, even when we_i targets x0.
  - Else if we_i=1 and waddr_i = raddr_n_i: rdata_n_o <= wdata_i (bypass; new value wins).
  - Else: rdata_n_o <= array[raddr_n_i] (old contents).
- Latency:
  - Address presented in cycle N; data valid after posedge N+1.
  - A write committed at posedge N is visible in the array from cycle N+1.
- Simultaneous events:
  - Both ports may read the same address; both bypass identically.
  - Read and write of different addresses are independent.
- Debug port:
  - dbg_data_o = array[dbg_addr_i] combinationally; 0 for x0.
  - Reflects a write only after the posedge that commits it.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared defines header holds:
  - `RADDR_WIDTH, `RDATA_WIDTH, `ZERO_REG, `ZERO, `WRITE_ENABLE, `READ_ENABLE.
  - Stall-vector bit indices (STALL_ID=1) for use across pipeline stages.
- One sub-module: regfile_rd_port. It holds one registered read port: the priority mux (stall / enable / x0 / bypass / array) plus its output flop. It is instantiated twice.
- The array and write logic stay in the top module.

Test Plan:
1. Reset behaviour: write 0xDEADBEEF to x5, pulse rst_ni low mid-cycle. rdata1_o/rdata2_o go to 0 immediately, and a read of x5 after reset returns 0.
2. Basic write/read: write x3=0x12345678 at cycle 0; read port 1 of x3 at cycle 2 gives rdata1_o=0x12345678 after the next posedge. Port 2 reading x4 returns 0.
3. Bypass: in the same cycle, we_i=1, waddr_i=7, wdata_i=0xA5A5A5A5, raddr1_i=raddr2_i=7 with x7 previously 0x1. Both outputs give 0xA5A5A5A5 after the posedge.
4. x0 protection: we_i=1 to x0 with 0xFFFFFFFF while port 1 reads x0 in the same cycle. rdata1_o=0 then and afterward, and dbg_data_o=0 for dbg_addr_i=0.
5. Stall hold: rdata1_o=0x11 from x9. Assert stall_i=6'b000010 for 3 cycles while writing x9=0x22 and changing raddr1_i to 10. rdata1_o stays 0x11 throughout. On release with raddr1_i=9, rdata1_o=0x22.
6. Read enable low: re2_i=0 with raddr2_i=3 (x3=0x12345678) gives rdata2_o=0. The debug port with dbg_addr_i=3 shows 0x12345678 combinationally.

Source files
------------

// File: rtl/regfile_rd_pkg.sv
// Shared constants and read-source selection for the write-back register file.
// Every pipeline stage that indexes the stall vector or sizes a register operand uses these.
package regfile_rd_pkg;

    localparam int DEF_RADDR_WIDTH = 5;
    localparam int DEF_RDATA_WIDTH = 32;
    localparam int STALL_WIDTH     = 6;
    localparam int STALL_ID        = 1;

    localparam logic [DEF_RADDR_WIDTH-1:0] ZERO_REG     = '0;
    localparam logic [DEF_RDATA_WIDTH-1:0] ZERO         = '0;
    localparam logic                       WRITE_ENABLE = 1'b1;
    localparam logic                       READ_ENABLE  = 1'b1;

    typedef enum logic [1:0] {
        RD_HOLD   = 2'd0,
        RD_ZERO   = 2'd1,
        RD_BYPASS = 2'd2,
        RD_ARRAY  = 2'd3
    } rd_src_e;

    // Priority order matters: a stall beats everything, and x0 beats the bypass.
    function automatic rd_src_e readSource(input logic hold, input logic enabled,
                                           input logic isZeroReg, input logic bypassHit);
        if (hold)            return RD_HOLD;
        else if (!enabled)   return RD_ZERO;
        else if (isZeroReg)  return RD_ZERO;
        else if (bypassHit)  return RD_BYPASS;
        else                 return RD_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: priority mux (stall / enable / x0 / bypass / array)
// feeding the output flop.
module regfile_rd_port
    import regfile_rd_pkg::*;
#(
    parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
    parameter int RDATA_WIDTH = DEF_RDATA_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hold_i,
    input  logic                   re_i,
    input  logic [RADDR_WIDTH-1:0] raddr_i,
    input  logic                   we_i,
    input  logic [RADDR_WIDTH-1:0] waddr_i,
    input  logic [RDATA_WIDTH-1:0] wdata_i,
    input  logic [RDATA_WIDTH-1:0] arr_data_i,
    output logic [RDATA_WIDTH-1:0] rdata_o
);

    rd_src_e                src;
    logic [RDATA_WIDTH-1:0] rdata_d;
    logic [RDATA_WIDTH-1:0] rdata_q;

    always_comb begin
        src = readSource(hold_i,
                         re_i == READ_ENABLE,
                         raddr_i == RADDR_WIDTH'(ZERO_REG),
                         (we_i == WRITE_ENABLE) && (waddr_i == raddr_i));
    end

    always_comb begin
        rdata_d = rdata_q;
        case (src)
            RD_HOLD:   rdata_d = rdata_q;
            RD_ZERO:   rdata_d = RDATA_WIDTH'(ZERO);
            RD_BYPASS: rdata_d = wdata_i;
            RD_ARRAY:  rdata_d = arr_data_i;
            default:   rdata_d = rdata_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_rd.sv
// General-purpose register file: one write port from MEM/WB, two registered
// read ports with write-through bypass for ID, and a combinational debug port.
module regfile_rd
    import regfile_rd_pkg::*;
#(
    parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
    parameter int RDATA_WIDTH = DEF_RDATA_WIDTH,
    parameter int STALL_BIT   = STALL_ID
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   we_i,
    input  logic [RADDR_WIDTH-1:0] waddr_i,
    input  logic [RDATA_WIDTH-1:0] wdata_i,
    input  logic                   re1_i,
    input  logic [RADDR_WIDTH-1:0] raddr1_i,
    output logic [RDATA_WIDTH-1:0] rdata1_o,
    input  logic                   re2_i,
    input  logic [RADDR_WIDTH-1:0] raddr2_i,
    output logic [RDATA_WIDTH-1:0] rdata2_o,
    input  logic [RADDR_WIDTH-1:0] dbg_addr_i,
    output logic [RDATA_WIDTH-1:0] dbg_data_o
);

    localparam int NUM_REGS = 2 ** RADDR_WIDTH;

    logic [RDATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                   holdRead;
    logic [STALL_WIDTH-1:0] stall_unused;

    // Only the ID bit matters here; the rest of the vector belongs to other stages.
    assign holdRead     = stall_i[STALL_BIT];
    assign stall_unused = stall_i;

    // x0 is never written, so its entry stays at the reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if ((we_i == WRITE_ENABLE) && (waddr_i != RADDR_WIDTH'(ZERO_REG))) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign dbg_data_o = (dbg_addr_i == RADDR_WIDTH'(ZERO_REG)) ? RDATA_WIDTH'(ZERO)
                                                               : regs_q[dbg_addr_i];

    regfile_rd_port #(
        .RADDR_WIDTH (RADDR_WIDTH),
        .RDATA_WIDTH (RDATA_WIDTH)
    ) u_port1 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .hold_i     (holdRead),
        .re_i       (re1_i),
        .raddr_i    (raddr1_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .arr_data_i (regs_q[raddr1_i]),
        .rdata_o    (rdata1_o)
    );

    regfile_rd_port #(
        .RADDR_WIDTH (RADDR_WIDTH),
        .RDATA_WIDTH (RDATA_WIDTH)
    ) u_port2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .hold_i     (holdRead),
        .re_i       (re2_i),
        .raddr_i    (raddr2_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .arr_data_i (regs_q[raddr2_i]),
        .rdata_o    (rdata2_o)
    );

endmodule

// File: tb/tb_regfile_rd.sv
// Directed-vector bench for regfile_rd: reset, write/read, bypass, x0, stall hold,
// read-enable and debug port, with hand-computed expected values.
module tb_regfile_rd;

    logic        clk;
    logic        rstN;
    logic [5:0]  stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbgAddr;
    logic [31:0] dbgData;

    int checkCount;
    int failCount;

    regfile_rd dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .stall_i    (stall),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .re1_i      (re1),
        .raddr1_i   (raddr1),
        .rdata1_o   (rdata1),
        .re2_i      (re2),
        .raddr2_i   (raddr2),
        .rdata2_o   (rdata2),
        .dbg_addr_i (dbgAddr),
        .dbg_data_o (dbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of inputs, then step past the next posedge.
    task automatic applyStimulus(input logic [5:0] stallV, input logic weV,
                                 input logic [4:0] waddrV, input logic [31:0] wdataV,
                                 input logic re1V, input logic [4:0] raddr1V,
                                 input logic re2V, input logic [4:0] raddr2V);
        stall  = stallV;
        we     = weV;
        waddr  = waddrV;
        wdata  = wdataV;
        re1    = re1V;
        raddr1 = raddr1V;
        re2    = re2V;
        raddr2 = raddr2V;
        @(posedge clk);
        #1;
    endtask

    task automatic peekDebug(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        dbgAddr = addr;
        #1;
        checkOutput(tag, dbgData, expected);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rstN    = 1'b0;
        stall   = '0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        re1     = 1'b0;
        raddr1  = '0;
        re2     = 1'b0;
        raddr2  = '0;
        dbgAddr = '0;
        $display("[TB] start");

        @(posedge clk);
        #1;
        checkOutput("reset rdata1", rdata1, 32'h0);
        checkOutput("reset rdata2", rdata2, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Reset behaviour: fill x5, read it, then pulse reset mid-cycle
        applyStimulus(6'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        checkOutput("pre-reset rdata1 x5", rdata1, 32'hDEADBEEF);
        checkOutput("pre-reset rdata2 x5", rdata2, 32'hDEADBEEF);
        #2;
        rstN = 1'b0;
        we   = 1'b1;
        waddr = 5'd5;
        wdata = 32'hCAFEF00D;
        #1;
        checkOutput("async reset rdata1", rdata1, 32'h0);
        checkOutput("async reset rdata2", rdata2, 32'h0);
        peekDebug("async reset dbg x5", 5'd5, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("write ignored in reset", dbgData, 32'h0);
        #2;
        rstN = 1'b1;
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        checkOutput("post-reset rdata1 x5", rdata1, 32'h0);

        // Basic write then read, unwritten register reads as zero
        applyStimulus(6'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
        checkOutput("read x3", rdata1, 32'h12345678);
        checkOutput("read x4", rdata2, 32'h0);

        // Bypass on both ports; debug port lags until the commit edge
        applyStimulus(6'b0, 1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 1'b0, 5'd0);
        stall = '0; we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        peekDebug("dbg x7 before commit", 5'd7, 32'h00000001);
        @(posedge clk);
        #1;
        checkOutput("bypass rdata1", rdata1, 32'hA5A5A5A5);
        checkOutput("bypass rdata2", rdata2, 32'hA5A5A5A5);
        peekDebug("dbg x7 after commit", 5'd7, 32'hA5A5A5A5);

        // Independent write to x12 while reading x3 returns the old x3 contents
        applyStimulus(6'b0, 1'b1, 5'd12, 32'h0BADF00D, 1'b1, 5'd3, 1'b1, 5'd12);
        checkOutput("independent read x3", rdata1, 32'h12345678);
        checkOutput("bypass x12 port2", rdata2, 32'h0BADF00D);

        // x0 protection
        applyStimulus(6'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        checkOutput("x0 write-read rdata1", rdata1, 32'h0);
        checkOutput("x0 write-read rdata2", rdata2, 32'h0);
        peekDebug("dbg x0", 5'd0, 32'h0);
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
        checkOutput("x0 afterwards", rdata1, 32'h0);

        // Stall hold: writes continue, outputs freeze
        applyStimulus(6'b0, 1'b1, 5'd9, 32'h00000011, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3);
        checkOutput("pre-stall rdata1", rdata1, 32'h00000011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b000010, 1'b1, 5'd9, 32'h00000022, 1'b1, 5'd10, 1'b0, 5'd0);
            checkOutput($sformatf("stall hold rdata1 %0d", i), rdata1, 32'h00000011);
            checkOutput($sformatf("stall hold rdata2 %0d", i), rdata2, 32'h12345678);
        end
        peekDebug("write during stall", 5'd9, 32'h00000022);
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd10);
        checkOutput("post-stall rdata1", rdata1, 32'h00000022);
        checkOutput("post-stall rdata2", rdata2, 32'h0);

        // Stall bits other than the ID bit do not freeze the ports
        applyStimulus(6'b111101, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd9);
        checkOutput("other stall bits rdata1", rdata1, 32'h12345678);
        checkOutput("other stall bits rdata2", rdata2, 32'h00000022);

        // Read enable low forces zero; debug still sees the array
        applyStimulus(6'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd3);
        checkOutput("re2 low rdata2", rdata2, 32'h0);
        checkOutput("re1 high rdata1", rdata1, 32'h00000022);
        peekDebug("dbg x3", 5'd3, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
